// File: rtl/cpu_params_pkg.sv
// CPU-wide sizing for the general purpose register file and a one-hot helper
// used by anything that tracks per-register state.
package cpu_params_pkg;

  localparam int MAX_GPR = 32;
  localparam int RSZ     = 32;
  localparam int GPR_ASZ = $clog2(MAX_GPR);

  function automatic logic [MAX_GPR-1:0] gpr_onehot(input logic [GPR_ASZ-1:0] a);
    gpr_onehot    = '0;
    gpr_onehot[a] = 1'b1;
  endfunction

endpackage

// File: rtl/cpu_structs_pkg.sv
// Shared request types for the write-back path.
package cpu_structs_pkg;
  import cpu_params_pkg::*;

  typedef struct packed {
    logic               wr;
    logic [GPR_ASZ-1:0] addr;
    logic [RSZ-1:0]     data;
  } wb_req_t;

  localparam int WB_STARVE_LIMIT_DFLT = 4;

endpackage

// File: rtl/RBUS_intf.sv
// GPR write bus: one registered write port into the register file.
interface RBUS_intf;
  import cpu_params_pkg::*;

  logic               Rd_wr;
  logic [GPR_ASZ-1:0] Rd_addr;
  logic [RSZ-1:0]     Rd_data;

  modport master (output Rd_wr, Rd_addr, Rd_data);
  modport slave  (input  Rd_wr, Rd_addr, Rd_data);

endinterface

// File: rtl/wb_arbiter.sv
// Two-way write-back arbiter: MDU over MEM. With WB_FAIRNESS_EN defined a
// starvation counter hands MEM one grant after STARVE_LIMIT denied cycles.
module wb_arbiter
  import cpu_params_pkg::*, cpu_structs_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DFLT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic               mem_rd_wr,
  input  logic [GPR_ASZ-1:0] mem_rd_addr,
  input  logic [RSZ-1:0]     mem_rd_data,
  input  logic               mdu_valid,
  output logic               mdu_ready,
  input  logic [GPR_ASZ-1:0] mdu_rd_addr,
  input  logic [RSZ-1:0]     mdu_rd_data,
  output logic               grant,
  output wb_req_t            req
);

  logic mem_prio;
  logic mem_acc;
  logic mdu_acc;

`ifdef WB_FAIRNESS_EN
  localparam int            CW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] CMAX = CW'(STARVE_LIMIT);

  logic [CW-1:0] starve_q;

  // Counts only consecutive denials of a waiting MEM result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         starve_q <= '0;
    else if (!mem_valid || mem_ready) starve_q <= '0;
    else if (starve_q != CMAX)       starve_q <= starve_q + CW'(1);
  end

  assign mem_prio = (starve_q == CMAX);
`else
  localparam int unused_limit = STARVE_LIMIT;
  logic          unused_clk;

  assign unused_clk = clk;
  assign mem_prio   = 1'b0;
`endif

  assign mdu_ready = !rst && !mem_prio;
  assign mem_ready = !rst && !(mdu_valid && !mem_prio);

  assign mdu_acc = mdu_valid && mdu_ready;
  assign mem_acc = mem_valid && mem_ready;
  assign grant   = mdu_acc || mem_acc;

  // R0 and no-write MEM results are still consumed, just without a bus write.
  always_comb begin
    req = '0;
    if (mdu_acc) begin
      req.wr   = (mdu_rd_addr != '0);
      req.addr = mdu_rd_addr;
      req.data = mdu_rd_data;
    end else if (mem_acc) begin
      req.wr   = mem_rd_wr && (mem_rd_addr != '0);
      req.addr = mem_rd_addr;
      req.data = mem_rd_data;
    end
  end

endmodule

// File: rtl/wb_gpr_writer.sv
// Write-back unit: merges MEM and MDU results onto the GPR write bus and keeps
// the pending-write scoreboard for decode. Optional fairness: WB_FAIRNESS_EN.
module wb_gpr_writer
  import cpu_params_pkg::*, cpu_structs_pkg::*;
#(
  parameter int STARVE_LIMIT = WB_STARVE_LIMIT_DFLT
) (
  input  logic               clk_in,
  input  logic               reset_in,
  input  logic               mem_valid,
  output logic               mem_ready,
  input  logic               mem_rd_wr,
  input  logic [GPR_ASZ-1:0] mem_rd_addr,
  input  logic [RSZ-1:0]     mem_rd_data,
  input  logic               mdu_valid,
  output logic               mdu_ready,
  input  logic [GPR_ASZ-1:0] mdu_rd_addr,
  input  logic [RSZ-1:0]     mdu_rd_data,
  input  logic               issue_set,
  input  logic [GPR_ASZ-1:0] issue_addr,
  output logic [MAX_GPR-1:0] pending,
  RBUS_intf.master           gpr_bus
);

  logic               grant;
  wb_req_t            sel;
  logic               rd_wr_q;
  logic [GPR_ASZ-1:0] rd_addr_q;
  logic [RSZ-1:0]     rd_data_q;
  logic [MAX_GPR-1:0] pend_q;
  logic [MAX_GPR-1:0] pend_set;
  logic [MAX_GPR-1:0] pend_clr;

  wb_arbiter #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_arb (
    .clk         (clk_in),
    .rst         (reset_in),
    .mem_valid   (mem_valid),
    .mem_ready   (mem_ready),
    .mem_rd_wr   (mem_rd_wr),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mdu_valid   (mdu_valid),
    .mdu_ready   (mdu_ready),
    .mdu_rd_addr (mdu_rd_addr),
    .mdu_rd_data (mdu_rd_data),
    .grant       (grant),
    .req         (sel)
  );

  // Address/data hold when idle so the bus only toggles on real traffic.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      rd_wr_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      rd_wr_q <= grant && sel.wr;
      if (grant) begin
        rd_addr_q <= sel.addr;
        rd_data_q <= sel.data;
      end
    end
  end

  assign gpr_bus.Rd_wr   = rd_wr_q;
  assign gpr_bus.Rd_addr = rd_addr_q;
  assign gpr_bus.Rd_data = rd_data_q;

  assign pend_clr = rd_wr_q ? gpr_onehot(rd_addr_q) : '0;
  assign pend_set = (issue_set && issue_addr != '0) ? gpr_onehot(issue_addr) : '0;

  // Set after clear: a same-edge issue means a newer writer is in flight.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) pend_q <= '0;
    else          pend_q <= ((pend_q & ~pend_clr) | pend_set) & ~MAX_GPR'(1);
  end

  assign pending = pend_q;

endmodule

// File: tb/tb_wb_gpr_writer.sv
// Randomized bench for wb_gpr_writer against a register-file level model.
module tb_wb_gpr_writer;
  import cpu_params_pkg::*;

  localparam int SL = 4;

  logic               clk_in = 1'b0;
  logic               reset_in = 1'b1;
  logic               mem_valid = 1'b0, mem_rd_wr = 1'b0;
  logic [GPR_ASZ-1:0] mem_rd_addr = '0;
  logic [RSZ-1:0]     mem_rd_data = '0;
  logic               mdu_valid = 1'b0;
  logic [GPR_ASZ-1:0] mdu_rd_addr = '0;
  logic [RSZ-1:0]     mdu_rd_data = '0;
  logic               issue_set = 1'b0;
  logic [GPR_ASZ-1:0] issue_addr = '0;
  logic               mem_ready, mdu_ready;
  logic [MAX_GPR-1:0] pending;

  RBUS_intf gpr_bus();

  wb_gpr_writer #(.STARVE_LIMIT(SL)) dut (
    .clk_in(clk_in), .reset_in(reset_in),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd_wr(mem_rd_wr),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready),
    .mdu_rd_addr(mdu_rd_addr), .mdu_rd_data(mdu_rd_data),
    .issue_set(issue_set), .issue_addr(issue_addr),
    .pending(pending), .gpr_bus(gpr_bus)
  );

  always #5 clk_in = ~clk_in;

  // Register file fed by the bus, as the real gpr would be.
  logic [RSZ-1:0] gpr [MAX_GPR] = '{default: '0};
  always @(posedge clk_in)
    if (gpr_bus.Rd_wr === 1'b1) gpr[gpr_bus.Rd_addr] <= gpr_bus.Rd_data;

  // Reference state: expected bus registers, scoreboard, register file.
  logic               m_wr;
  logic [GPR_ASZ-1:0] m_addr;
  logic [RSZ-1:0]     m_data;
  logic [MAX_GPR-1:0] m_pend;
  logic [RSZ-1:0]     m_gpr [MAX_GPR] = '{default: '0};
  int                 m_cnt;
  int                 lw;
  int                 n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_wr = 1'b0; m_addr = '0; m_data = '0; m_pend = '0; m_cnt = 0;
  endtask

  task automatic do_reset();
    mem_valid = 1'b0; mdu_valid = 1'b0; issue_set = 1'b0;
    reset_in = 1'b1;
    #1;
    chk("rst_rd_wr", gpr_bus.Rd_wr, 0);
    chk("rst_pending", pending, 0);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_mdu_ready", mdu_ready, 0);
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_rd_addr", gpr_bus.Rd_addr, 0);
    chk("rst_rd_data", gpr_bus.Rd_data, 0);
    chk("rst_rd_wr_held", gpr_bus.Rd_wr, 0);
    reset_in = 1'b0;
    model_reset();
    @(posedge clk_in); #1;
  endtask

  // One clock cycle: drive, check at negedge, advance the model, move past the edge.
  task automatic step(input logic mv, input logic mw, input logic [GPR_ASZ-1:0] ma,
                      input logic [RSZ-1:0] md, input logic dv,
                      input logic [GPR_ASZ-1:0] da, input logic [RSZ-1:0] dd,
                      input logic iv, input logic [GPR_ASZ-1:0] ia,
                      output logic macc, output logic dacc, output logic obs_mrdy);
    logic prio;
    mem_valid = mv; mem_rd_wr = mw; mem_rd_addr = ma; mem_rd_data = md;
    mdu_valid = dv; mdu_rd_addr = da; mdu_rd_data = dd;
    issue_set = iv; issue_addr = ia;
    @(negedge clk_in);
`ifdef WB_FAIRNESS_EN
    prio = (m_cnt == SL);
`else
    prio = 1'b0;
`endif
    chk("mdu_ready", mdu_ready, !prio);
    chk("mem_ready", mem_ready, !(dv && !prio));
    chk("rd_wr", gpr_bus.Rd_wr, m_wr);
    chk("rd_addr", gpr_bus.Rd_addr, m_addr);
    chk("rd_data", gpr_bus.Rd_data, m_data);
    chk("pending", pending, m_pend);
    chk("gpr_last", gpr[lw], m_gpr[lw]);
    obs_mrdy = mem_ready;
    dacc = dv && !prio;
    macc = mv && !(dv && !prio);
    if (m_wr) begin
      m_gpr[m_addr] = m_data;
      m_pend[m_addr] = 1'b0;
      lw = int'(m_addr);
    end
    if (iv && ia != 0) m_pend[ia] = 1'b1;
    if (dacc) begin
      m_wr = (da != 0); m_addr = da; m_data = dd;
    end else if (macc) begin
      m_wr = mw && (ma != 0); m_addr = ma; m_data = md;
    end else m_wr = 1'b0;
    if (!mv || macc) m_cnt = 0;
    else if (m_cnt < SL) m_cnt++;
    @(posedge clk_in); #1;
  endtask

  task automatic idle();
    logic a, b, c;
    step(0, 0, '0, '0, 0, '0, '0, 0, '0, a, b, c);
  endtask

  function automatic logic [GPR_ASZ-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? '0 : GPR_ASZ'($urandom_range(1, MAX_GPR - 1));
  endfunction

  initial begin
    logic ma_, da_, om;
    logic hm, hd, mw, iv;
    logic [GPR_ASZ-1:0] ma, da, ia;
    logic [RSZ-1:0] md, dd;
    int first_mem;
    lw = 0;
    model_reset();
    do_reset();

    // Single MEM write with its scoreboard bit set beforehand.
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd5, ma_, da_, om);
    step(1, 1, 5'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, ma_, da_, om);
    chk("t1_mem_acc", om, 1);
    chk("t1_rd_wr", gpr_bus.Rd_wr, 1);
    chk("t1_rd_addr", gpr_bus.Rd_addr, 5);
    chk("t1_rd_data", gpr_bus.Rd_data, 32'hDEADBEEF);
    chk("t1_pend_n1", pending[5], 1);
    idle();
    chk("t1_gpr5", gpr[5], 32'hDEADBEEF);
    chk("t1_pend_n2", pending[5], 0);

    // Simultaneous results: MDU first, MEM next cycle.
    step(1, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22, 0, '0, ma_, da_, om);
    chk("t2_mem_ready_first", om, 0);
    chk("t2_first_addr", gpr_bus.Rd_addr, 4);
    step(1, 1, 5'd3, 32'h11, 0, '0, '0, 0, '0, ma_, da_, om);
    chk("t2_second_addr", gpr_bus.Rd_addr, 3);
    chk("t2_second_data", gpr_bus.Rd_data, 32'h11);
    idle(); idle();
    chk("t2_gpr4", gpr[4], 32'h22);
    chk("t2_gpr3", gpr[3], 32'h11);

    // R0 write is consumed silently.
    step(1, 1, 5'd0, 32'hFFFFFFFF, 0, '0, '0, 0, '0, ma_, da_, om);
    chk("t3_mem_ready", om, 1);
    chk("t3_rd_wr", gpr_bus.Rd_wr, 0);
    idle();
    chk("t3_gpr0", gpr[0], 0);

    // Issue to R7 on the same edge its write completes: set wins.
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7, ma_, da_, om);
    step(1, 1, 5'd7, 32'h77, 0, '0, '0, 0, '0, ma_, da_, om);
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd7, ma_, da_, om);
    chk("t4_pend7", pending[7], 1);
    chk("t4_gpr7", gpr[7], 32'h77);

    // MEM competing with a continuous MDU stream.
    first_mem = -1;
    hm = 1'b1;
    for (int c = 0; c < 8; c++) begin
      step(hm, 1, 5'd10, 32'hA0A0, 1, GPR_ASZ'(11 + c), RSZ'(c), 0, '0, ma_, da_, om);
      if (hm && om) begin
        if (first_mem < 0) first_mem = c;
        hm = 1'b0;
      end
    end
`ifdef WB_FAIRNESS_EN
    chk("t5_mem_cycle", 64'(first_mem), 64'(SL));
`else
    chk("t5_mem_starved", 64'(first_mem), 64'(-1));
`endif
    step(1, 1, 5'd10, 32'hA0A0, 0, '0, '0, 0, '0, ma_, da_, om);
    idle(); idle();

    // Reset right after an accepted R9 write kills the bus write.
    step(0, 0, '0, '0, 0, '0, '0, 1, 5'd9, ma_, da_, om);
    step(1, 1, 5'd9, 32'h99, 0, '0, '0, 0, '0, ma_, da_, om);
    chk("t6_wr_before", gpr_bus.Rd_wr, 1);
    mem_valid = 1'b0;
    do_reset();
    chk("t6_gpr9", gpr[9], 0);

    // Random traffic; each source holds its request until accepted.
    hm = 1'b0; hd = 1'b0; mw = 1'b0; ma = '0; md = '0; da = '0; dd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!hm && $urandom_range(0, 2) == 0) begin
        hm = 1'b1; mw = ($urandom_range(0, 3) != 0); ma = rand_addr(); md = $urandom;
      end
      if (!hd && $urandom_range(0, 3) == 0) begin
        hd = 1'b1; da = rand_addr(); dd = $urandom;
      end
      iv = ($urandom_range(0, 3) == 0);
      ia = rand_addr();
      step(hm, mw, ma, md, hd, da, dd, iv, ia, ma_, da_, om);
      if (ma_) hm = 1'b0;
      if (da_) hd = 1'b0;
    end
    idle(); idle();
    for (int i = 0; i < MAX_GPR; i++) chk($sformatf("final_gpr%0d", i), gpr[i], m_gpr[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
